// File: rtl/fifo_pkg.sv
// Shared width helpers and access-op encoding for the fifo_sync elastic buffer.
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } op_e;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DWIDTH register array: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8,
    parameter int AWIDTH = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, sticky
// error flags and optional first-word-fall-through output.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DWIDTH    = 16,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DWIDTH-1:0]          din,
    input  logic                       rd_en,
    output logic [DWIDTH-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync: DEPTH must be >= 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("fifo_sync: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync: AEMPTY_TH must be in 0..DEPTH-1");
    end

    ptr_t              wptr;
    ptr_t              rptr;
    cnt_t              count_q;
    logic              ovf_q;
    logic              unf_q;
    logic              rd_acc;
    logic              wr_acc;
    op_e               op;
    logic [DWIDTH-1:0] rdata;

    // Explicit wrap so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == cnt_t'(DEPTH));
    assign almost_full  = (count_q >= cnt_t'(AFULL_TH));
    assign almost_empty = (count_q <= cnt_t'(AEMPTY_TH));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);
    assign op     = op_e'({wr_acc, rd_acc});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= ptr_inc(wptr);
            end
            if (rd_acc) begin
                rptr <= ptr_inc(rptr);
            end
            case (op)
                OP_WR:   count_q <= count_q + cnt_t'(1);
                OP_RD:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
            ovf_q <= (wr_en & ~wr_acc) | (ovf_q & ~err_clr);
            unf_q <= (rd_en & ~rd_acc) | (unf_q & ~err_clr);
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (din),
        .raddr (rptr),
        .rdata (rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign dout = rdata;
    end else begin : g_std
        logic [DWIDTH-1:0] dout_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rdata;
            end
        end

        assign dout = dout_q;
    end

endmodule
